conv_win_sched: RTL and testbench

- Sequencer that drives the combinational 3x3 convolution unit across a whole input feature map (IFM).
- Reads IFM pixels from a single-port SRAM with 1-cycle read latency and assembles each K_H x K_W window in registers.
- Presents the window on a flat bus to the external conv unit, takes its ReLU'd 24-bit result, and writes it to the output feature map (OFM) SRAM.
- Stride 1, no padding, raster order. Weights are loaded elsewhere.

---
 rtl/conv_win_sched.sv | 215 +++++++++++++++++++++
 tb/tb_conv_win_sched.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_win_sched.sv
// conv_win_sched: raster-order window sequencer for an external combinational
// K_H x K_W convolution unit. Stride 1, no padding.
//
// For every output position it streams the K_H*K_W window pixels out of a
// single-port IFM SRAM (1-cycle read latency) into win_bus. It then spends one
// cycle letting the conv unit settle on the complete window. The conv result
// is registered and written to the OFM SRAM in the following cycle.
// Each output costs 11 cycles (9 FETCH, 1 LAST, 1 CALC) for a 3x3 kernel.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle job request, only honoured in IDLE
//   busy, done    job in progress / one-cycle end-of-job pulse
//   ifm_rd_*      IFM SRAM read strobe, address and returned data
//   win_bus       flat window, element (i,j) at [(i*K_W+j)*DATA_WIDTH +: DATA_WIDTH]
//   conv_result   combinational conv unit output for win_bus
//   ofm_wr_*      OFM SRAM write strobe, address and data
//   busy_cycles   (only with CONV_WIN_SCHED_PERF_EN) saturating count of busy cycles
//
// Optional feature macro: CONV_WIN_SCHED_PERF_EN adds the busy_cycles counter.
module conv_win_sched #(
  parameter int unsigned IMG_H      = 5,
  parameter int unsigned IMG_W      = 5,
  parameter int unsigned K_H        = 3,
  parameter int unsigned K_W        = 3,
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              ifm_rd_en,
  output logic [ADDR_W-1:0]                 ifm_rd_addr,
  input  logic [DATA_WIDTH-1:0]             ifm_rd_data,
  output logic [K_H*K_W*DATA_WIDTH-1:0]     win_bus,
  input  logic [23:0]                       conv_result,
  output logic                              ofm_wr_en,
  output logic [ADDR_W-1:0]                 ofm_wr_addr,
  output logic [23:0]                       ofm_wr_data
`ifdef CONV_WIN_SCHED_PERF_EN
  ,
  output logic [31:0]                       busy_cycles
`endif
);

  localparam int unsigned OUT_H  = IMG_H - K_H + 1;
  localparam int unsigned OUT_W  = IMG_W - K_W + 1;
  localparam int unsigned WinN   = K_H * K_W;
  localparam int unsigned KIdxW  = (WinN > 1) ? $clog2(WinN) : 1;

  localparam logic [ADDR_W-1:0] AOne  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ImgWA = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] OutWA = ADDR_W'(OUT_W);
  localparam logic [ADDR_W-1:0] OutHA = ADDR_W'(OUT_H);
  localparam logic [ADDR_W-1:0] KWA   = ADDR_W'(K_W);
  localparam logic [KIdxW-1:0]  KOne  = KIdxW'(1);
  localparam logic [KIdxW-1:0]  KLast = KIdxW'(WinN - 1);

  // Elaboration-time sanity checks on the geometry.
  if (IMG_H < K_H || IMG_W < K_W) begin : g_bad_geom
    $error("conv_win_sched: IFM smaller than kernel is unsupported");
  end
  if (longint'(IMG_H) * longint'(IMG_W) > (longint'(1) << ADDR_W)) begin : g_bad_addr
    $error("conv_win_sched: ADDR_W too narrow for IMG_H*IMG_W");
  end

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLast,
    StCalc,
    StDone
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   r_q, c_q;     // output position
  logic [KIdxW-1:0]    k_q;          // tap index within the window
  logic [ADDR_W-1:0]   kr_q, kc_q;   // k_q split into row/col, avoids a divider

  logic [ADDR_W-1:0]   kr_nxt, kc_nxt, r_nxt, c_nxt;
  logic [ADDR_W-1:0]   fetch_addr, win_addr, ofm_addr;
  logic                last_pos, last_tap;
  logic                cap_en;
  logic [KIdxW-1:0]    cap_idx;

  always_comb begin
    kc_nxt = kc_q + AOne;
    kr_nxt = kr_q;
    if (kc_q == KWA - AOne) begin
      kc_nxt = '0;
      kr_nxt = kr_q + AOne;
    end

    c_nxt = c_q + AOne;
    r_nxt = r_q;
    if (c_q == OutWA - AOne) begin
      c_nxt = '0;
      r_nxt = r_q + AOne;
    end

    last_pos = (c_q == OutWA - AOne) && (r_q == OutHA - AOne);
    last_tap = (k_q == KLast);

    // Address of the tap after the current one, and of tap 0 of the next window.
    fetch_addr = (r_q + kr_nxt) * ImgWA + (c_q + kc_nxt);
    win_addr   = r_nxt * ImgWA + c_nxt;
    ofm_addr   = r_q * OutWA + c_q;

    // Read data lags the strobe by one cycle, so tap k lands while k+1 is issued.
    cap_en  = ((state_q == StFetch) && (k_q != '0)) || (state_q == StLast);
    cap_idx = (state_q == StLast) ? KLast : (k_q - KOne);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      r_q         <= '0;
      c_q         <= '0;
      k_q         <= '0;
      kr_q        <= '0;
      kc_q        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ifm_rd_en   <= 1'b0;
      ifm_rd_addr <= '0;
      win_bus     <= '0;
      ofm_wr_en   <= 1'b0;
      ofm_wr_addr <= '0;
      ofm_wr_data <= '0;
    end else begin
      done      <= 1'b0;
      ofm_wr_en <= 1'b0;

      for (int unsigned e = 0; e < WinN; e++) begin
        if (cap_en && (cap_idx == KIdxW'(e))) begin
          win_bus[e*DATA_WIDTH +: DATA_WIDTH] <= ifm_rd_data;
        end
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StFetch;
            busy        <= 1'b1;
            r_q         <= '0;
            c_q         <= '0;
            k_q         <= '0;
            kr_q        <= '0;
            kc_q        <= '0;
            ifm_rd_en   <= 1'b1;
            ifm_rd_addr <= '0;
          end
        end
        StFetch: begin
          if (last_tap) begin
            state_q   <= StLast;
            ifm_rd_en <= 1'b0;
          end else begin
            k_q         <= k_q + KOne;
            kr_q        <= kr_nxt;
            kc_q        <= kc_nxt;
            ifm_rd_addr <= fetch_addr;
          end
        end
        StLast: begin
          state_q <= StCalc;
        end
        StCalc: begin
          // Write lands in the next cycle: first FETCH of the next window or DONE.
          ofm_wr_en   <= 1'b1;
          ofm_wr_data <= conv_result;
          ofm_wr_addr <= ofm_addr;
          k_q         <= '0;
          kr_q        <= '0;
          kc_q        <= '0;
          if (last_pos) begin
            state_q <= StDone;
            done    <= 1'b1;
            r_q     <= '0;
            c_q     <= '0;
          end else begin
            state_q     <= StFetch;
            r_q         <= r_nxt;
            c_q         <= c_nxt;
            ifm_rd_en   <= 1'b1;
            ifm_rd_addr <= win_addr;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef CONV_WIN_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles <= '0;
    end else if ((state_q == StIdle) && start) begin
      busy_cycles <= '0;
    end else if (busy && (busy_cycles != 32'hFFFF_FFFF)) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_win_sched.sv
// Self-checking bench for conv_win_sched on a 5x5 IFM with a 3x3 kernel.
// An IFM SRAM model and a unit-weight-scaled ReLU conv model are attached.
module tb_conv_win_sched;

  localparam int DW = 9;
  localparam int AW = 10;
  localparam int NW = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done, ifm_rd_en;
  logic [AW-1:0]     ifm_rd_addr;
  logic [DW-1:0]     ifm_rd_data = '0;
  logic [NW*DW-1:0]  win_bus;
  logic [23:0]       conv_result;
  logic              ofm_wr_en;
  logic [AW-1:0]     ofm_wr_addr;
  logic [23:0]       ofm_wr_data;
`ifdef CONV_WIN_SCHED_PERF_EN
  logic [31:0]       busy_cycles;
`endif

  int pix_mode = 0;  // 0: pixel = address, 1: pixel = 1
  int weight   = 1;  // same weight on all nine taps
  int n_checks = 0;
  int n_fail   = 0;

  conv_win_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .ifm_rd_en   (ifm_rd_en),
    .ifm_rd_addr (ifm_rd_addr),
    .ifm_rd_data (ifm_rd_data),
    .win_bus     (win_bus),
    .conv_result (conv_result),
    .ofm_wr_en   (ofm_wr_en),
    .ofm_wr_addr (ofm_wr_addr),
    .ofm_wr_data (ofm_wr_data)
`ifdef CONV_WIN_SCHED_PERF_EN
    ,
    .busy_cycles (busy_cycles)
`endif
  );

  always #5 clk = ~clk;

  // IFM SRAM: one-cycle read latency.
  always @(posedge clk) begin
    if (ifm_rd_en) ifm_rd_data <= (pix_mode == 1) ? DW'(1) : DW'(ifm_rd_addr);
  end

  // Conv unit: 3x3 dot product with uniform weight, then ReLU.
  always_comb begin
    int acc;
    acc = 0;
    for (int e = 0; e < NW; e++) acc += weight * int'(win_bus[e*DW +: DW]);
    conv_result = (acc < 0) ? 24'd0 : 24'(acc);
  end

  typedef struct packed {
    int              pix_mode;
    int              weight;
    int              restart_a;  // busy-cycle index at which start is re-pulsed, -1 none
    int              restart_b;
    logic [215:0]    exp_ofm;    // element i at [i*24 +: 24]
  } vec_t;

  vec_t tbl [6];
  int   exp_rd [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};

  function automatic vec_t mk(input int pm, input int w, input int ra, input int rb,
                              input logic [215:0] e);
    vec_t v;
    v.pix_mode  = pm;
    v.weight    = w;
    v.restart_a = ra;
    v.restart_b = rb;
    v.exp_ofm   = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_rd_en"}, 64'(ifm_rd_en), 0);
    check({tag, "_rd_addr"}, 64'(ifm_rd_addr), 0);
    check({tag, "_win_bus_nonzero"}, 64'(win_bus != '0), 0);
    check({tag, "_wr_en"}, 64'(ofm_wr_en), 0);
    check({tag, "_wr_addr"}, 64'(ofm_wr_addr), 0);
    check({tag, "_wr_data"}, 64'(ofm_wr_data), 0);
`ifdef CONV_WIN_SCHED_PERF_EN
    check({tag, "_busy_cycles"}, 64'(busy_cycles), 0);
`endif
  endtask

  // Called at a negedge; pulses start and follows the job to completion.
  // Returns at the negedge of the first idle cycle after the job.
  task automatic run_job(input int ti);
    int          nbusy, nrd, nwr, ndone;
    bit          done_last, fin;
    logic [9:0]  rd_log [9];
    logic [9:0]  wa [9];
    logic [23:0] wd [9];
    pix_mode = tbl[ti].pix_mode;
    weight   = tbl[ti].weight;
    nbusy = 0; nrd = 0; nwr = 0; ndone = 0; done_last = 0; fin = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      if (busy) begin
        nbusy++;
        if (ifm_rd_en) begin
          if (nrd < 9) rd_log[nrd] = ifm_rd_addr;
          nrd++;
        end
        if (ofm_wr_en) begin
          if (nwr < 9) begin
            wa[nwr] = ofm_wr_addr;
            wd[nwr] = ofm_wr_data;
          end
          nwr++;
        end
        if (done) begin
          ndone++;
          done_last = ofm_wr_en && (ofm_wr_addr == 10'd8);
        end
        start = (nbusy == tbl[ti].restart_a) || (nbusy == tbl[ti].restart_b);
        @(negedge clk);
      end else begin
        fin = 1;
      end
    end
    start = 1'b0;
    check($sformatf("job%0d_finished", ti), 64'(fin), 1);
    check($sformatf("job%0d_busy_len", ti), 64'(nbusy), 100);
    check($sformatf("job%0d_rd_count", ti), 64'(nrd), 81);
    for (int i = 0; i < 9 && i < nrd; i++)
      check($sformatf("job%0d_rd_addr[%0d]", ti, i), 64'(rd_log[i]), 64'(exp_rd[i]));
    check($sformatf("job%0d_wr_count", ti), 64'(nwr), 9);
    for (int i = 0; i < 9 && i < nwr; i++) begin
      check($sformatf("job%0d_wr_addr[%0d]", ti, i), 64'(wa[i]), 64'(i));
      check($sformatf("job%0d_wr_data[%0d]", ti, i), 64'(wd[i]),
            64'(tbl[ti].exp_ofm[i*24 +: 24]));
    end
    check($sformatf("job%0d_done_pulses", ti), 64'(ndone), 1);
    check($sformatf("job%0d_done_with_last_write", ti), 64'(done_last), 1);
`ifdef CONV_WIN_SCHED_PERF_EN
    check($sformatf("job%0d_busy_cycles", ti), 64'(busy_cycles), 100);
`endif
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // OFM sums for pixel=address: 9*(5r+c)+54.
    tbl[0] = mk(0, 1, -1, -1, {24'd162, 24'd153, 24'd144, 24'd117, 24'd108, 24'd99,
                               24'd72, 24'd63, 24'd54});
    tbl[1] = mk(1, -1, -1, -1, {24'd0, 24'd0, 24'd0, 24'd0, 24'd0, 24'd0,
                                24'd0, 24'd0, 24'd0});
    tbl[2] = mk(0, 1, 5, 50, {24'd162, 24'd153, 24'd144, 24'd117, 24'd108, 24'd99,
                              24'd72, 24'd63, 24'd54});
    tbl[3] = mk(1, 1, -1, -1, {24'd9, 24'd9, 24'd9, 24'd9, 24'd9, 24'd9,
                               24'd9, 24'd9, 24'd9});
    tbl[4] = mk(0, 2, -1, -1, {24'd324, 24'd306, 24'd288, 24'd234, 24'd216, 24'd198,
                               24'd144, 24'd126, 24'd108});
    // start held during the DONE cycle must be ignored
    tbl[5] = mk(0, 1, 100, -1, {24'd162, 24'd153, 24'd144, 24'd117, 24'd108, 24'd99,
                                24'd72, 24'd63, 24'd54});

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 6; t++) begin
      run_job(t);
      repeat (2) @(negedge clk);
    end

    // Back-to-back: second start in the idle cycle right after DONE.
    run_job(0);
    run_job(0);
    @(negedge clk);

    // Reset in the middle of window 4 FETCH (busy cycles 45..53).
    pix_mode = 0;
    weight   = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (46) @(negedge clk);
    check("midjob_in_fetch", 64'(ifm_rd_en), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midjob_reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_job(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
